// File: rtl/echo_tof_pkg.sv
// Shared types and constants for the echo time-of-flight detector.
// The state encoding and error codes are also what the ARM register readback decodes.
package echo_tof_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        SEARCH1,
        PEAK1,
        HOLDOFF,
        SEARCH2,
        PEAK2,
        DONE
    } state_t;

    localparam int MID = 512;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_NO_E1 = 2'b01,
        ERR_NO_E2 = 2'b10
    } tof_err_t;

endpackage

// File: rtl/echo_tof_detect_if.sv
// Sample, configuration and result signals between the sampling stage and the TOF detector.
interface echo_tof_detect_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
);
    logic              burst_syn;
    logic [DATA_W-1:0] AD_data_in;
    logic              AD_data_valid;
    logic [DATA_W-2:0] threshold;
    logic [CNT_W-1:0]  blank_len;
    logic [CNT_W-1:0]  holdoff_len;
    logic [CNT_W-1:0]  gate_len;
    logic [CNT_W-1:0]  tof_out;
    logic [DATA_W-2:0] peak1_amp;
    logic [DATA_W-2:0] peak2_amp;
    logic              tof_valid;
    logic [1:0]        tof_err;
    logic              busy;

    modport master (
        output burst_syn, AD_data_in, AD_data_valid, threshold,
               blank_len, holdoff_len, gate_len,
        input  tof_out, peak1_amp, peak2_amp, tof_valid, tof_err, busy
    );

    modport slave (
        input  burst_syn, AD_data_in, AD_data_valid, threshold,
               blank_len, holdoff_len, gate_len,
        output tof_out, peak1_amp, peak2_amp, tof_valid, tof_err, busy
    );
endinterface

// File: rtl/echo_peak_track.sv
// Rectifies offset-binary samples and tracks the running maximum and its sample index.
// Priority is clear > load > enable; strict '>' keeps the earliest sample on ties.
module echo_peak_track
    import echo_tof_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_en,
    output logic [DATA_W-2:0] o_mag,
    output logic [DATA_W-2:0] o_max,
    output logic [CNT_W-1:0]  o_idx
);
    localparam logic [DATA_W:0] LP_MID = (DATA_W+1)'(MID);
    localparam logic [DATA_W:0] LP_MAX = (DATA_W+1)'({(DATA_W-1){1'b1}});

    // Distance from mid-scale; only d=0 overflows and is clamped to full scale.
    function automatic logic [DATA_W-2:0] rectify(input logic [DATA_W-1:0] d);
        logic [DATA_W:0] v_ext;
        logic [DATA_W:0] v_mag;
        v_ext = {1'b0, d};
        v_mag = (v_ext >= LP_MID) ? (v_ext - LP_MID) : (LP_MID - v_ext);
        return (v_mag > LP_MAX) ? {(DATA_W-1){1'b1}} : v_mag[DATA_W-2:0];
    endfunction

    logic [DATA_W-2:0] r_max;
    logic [CNT_W-1:0]  r_idx;

    assign o_mag = rectify(i_data);
    assign o_max = r_max;
    assign o_idx = r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_clr) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_max <= o_mag;
            r_idx <= i_cnt;
        end else if (i_en && (o_mag > r_max)) begin
            r_max <= o_mag;
            r_idx <= i_cnt;
        end
    end
endmodule

// File: rtl/echo_tof_detect.sv
// Per-burst detector: finds echo 1 and echo 2 peaks and reports their sample distance.
// A burst_syn rising edge always restarts the measurement, silently discarding any run in flight.
module echo_tof_detect
    import echo_tof_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    echo_tof_detect_if.slave  bus
);
    state_t            r_state;
    tof_err_t          r_err_pend;
    tof_err_t          r_tof_err;
    logic              r_burst_d;
    logic              r_busy;
    logic              r_tof_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hcnt;
    logic [CNT_W-1:0]  r_tof_out;
    logic [DATA_W-2:0] r_peak1;
    logic [DATA_W-2:0] r_peak2;

    logic              w_start;
    logic              w_vld;
    logic              w_gate;
    logic              w_blank_end;
    logic              w_hold_end;
    logic              w_above1;
    logic              w_above2;
    logic              w_ld1;
    logic              w_en1;
    logic              w_ld2;
    logic              w_en2;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-2:0] w_mag1;
    logic [DATA_W-2:0] w_mag2;
    logic [DATA_W-2:0] w_max1;
    logic [DATA_W-2:0] w_max2;
    logic [CNT_W-1:0]  w_idx1;
    logic [CNT_W-1:0]  w_idx2;

    assign w_start     = bus.burst_syn & ~r_burst_d;
    assign w_vld       = bus.AD_data_valid & ~w_start;
    assign w_gate      = (bus.gate_len != '0) && (r_cnt == bus.gate_len - CNT_W'(1));
    assign w_blank_end = (bus.blank_len == '0) || (r_cnt == bus.blank_len - CNT_W'(1));
    assign w_hold_end  = (bus.holdoff_len == '0) || (r_hcnt == bus.holdoff_len - CNT_W'(1));
    assign w_above1    = w_mag1 > bus.threshold;
    assign w_above2    = w_mag2 > bus.threshold;
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    assign w_ld1 = w_vld && (r_state == SEARCH1) && w_above1;
    assign w_en1 = w_vld && (r_state == PEAK1);
    assign w_ld2 = w_vld && (r_state == SEARCH2) && w_above2;
    assign w_en2 = w_vld && (r_state == PEAK2);

    echo_peak_track #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_echo1 (
        .clk    (clk),
        .reset  (reset),
        .i_data (bus.AD_data_in),
        .i_cnt  (r_cnt),
        .i_clr  (w_start),
        .i_load (w_ld1),
        .i_en   (w_en1),
        .o_mag  (w_mag1),
        .o_max  (w_max1),
        .o_idx  (w_idx1)
    );

    echo_peak_track #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_echo2 (
        .clk    (clk),
        .reset  (reset),
        .i_data (bus.AD_data_in),
        .i_cnt  (r_cnt),
        .i_clr  (w_start),
        .i_load (w_ld2),
        .i_en   (w_en2),
        .o_mag  (w_mag2),
        .o_max  (w_max2),
        .o_idx  (w_idx2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_err_pend  <= ERR_OK;
            r_tof_err   <= ERR_OK;
            r_burst_d   <= 1'b0;
            r_busy      <= 1'b0;
            r_tof_valid <= 1'b0;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_tof_out   <= '0;
            r_peak1     <= '0;
            r_peak2     <= '0;
        end else begin
            r_burst_d   <= bus.burst_syn;
            r_tof_valid <= 1'b0;
            if (w_start) begin
                r_state <= BLANK;
                r_cnt   <= '0;
                r_hcnt  <= '0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: ;
                    // DONE is not sample-qualified so the strobe latency stays fixed.
                    DONE: begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_tof_valid <= 1'b1;
                        r_tof_err   <= r_err_pend;
                        case (r_err_pend)
                            ERR_OK: begin
                                r_tof_out <= w_idx2 - w_idx1;
                                r_peak1   <= w_max1;
                                r_peak2   <= w_max2;
                            end
                            ERR_NO_E2: begin
                                r_tof_out <= '0;
                                r_peak1   <= w_max1;
                                r_peak2   <= '0;
                            end
                            default: begin
                                r_tof_out <= '0;
                                r_peak1   <= '0;
                                r_peak2   <= '0;
                            end
                        endcase
                    end
                    default: if (w_vld) begin
                        r_cnt <= w_cnt_inc;
                        case (r_state)
                            BLANK:   if (w_blank_end) r_state <= SEARCH1;
                            SEARCH1: if (w_above1) r_state <= PEAK1;
                            PEAK1: if (!w_above1) begin
                                r_state <= HOLDOFF;
                                r_hcnt  <= '0;
                            end
                            HOLDOFF: begin
                                r_hcnt <= r_hcnt + CNT_W'(1);
                                if (w_hold_end) r_state <= SEARCH2;
                            end
                            SEARCH2: if (w_above2) r_state <= PEAK2;
                            PEAK2: if (!w_above2) begin
                                r_state    <= DONE;
                                r_err_pend <= ERR_OK;
                            end
                            default: ;
                        endcase
                        // Gate closes the run; a run still inside echo 2 reports normally.
                        if (w_gate) begin
                            r_state <= DONE;
                            if ((r_state == BLANK) || (r_state == SEARCH1))
                                r_err_pend <= ERR_NO_E1;
                            else if (r_state == PEAK2)
                                r_err_pend <= ERR_OK;
                            else
                                r_err_pend <= ERR_NO_E2;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tof_out   = r_tof_out;
    assign bus.peak1_amp = r_peak1;
    assign bus.peak2_amp = r_peak2;
    assign bus.tof_valid = r_tof_valid;
    assign bus.tof_err   = r_tof_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_echo_tof_detect.sv
// Table-driven bench for echo_tof_detect with a result scoreboard and multi-cycle corner sequences.
module tb_echo_tof_detect;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    echo_tof_detect_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    echo_tof_detect #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int blank; int hold; int gate; int thr;
        int e1; int e2; int spike; bit tog;
        int close;
        int tof; int p1; int p2; int err;
    } case_t;

    typedef struct {
        int tof; int p1; int p2; int err; int cyc;
    } exp_t;

    exp_t  sb[$];
    exp_t  m_e;
    case_t cases[8];
    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Echo shapes: echo 1 peaks at mag 200 on its 2nd sample, echo 2 at mag 168 on its 2nd sample.
    function automatic int sample_at(int i, int e1, int e2, int spike);
        int s;
        s = 512;
        if (spike >= 0 && i == spike) s = 812;
        if (e1 >= 0 && i >= e1 && i < e1 + 4) begin
            case (i - e1)
                0: s = 612;
                1: s = 712;
                2: s = 662;
                default: s = 500;
            endcase
        end
        if (e2 >= 0 && i >= e2 && i < e2 + 3) begin
            case (i - e2)
                0: s = 600;
                1: s = 680;
                default: s = 560;
            endcase
        end
        return s;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest pending expectation.
    always begin
        @(posedge clk);
        #1;
        if (!reset && bus.tof_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'(bus.tof_valid), 0);
            end else begin
                m_e = sb.pop_front();
                check("tof_out",   int'(bus.tof_out),   m_e.tof);
                check("peak1_amp", int'(bus.peak1_amp), m_e.p1);
                check("peak2_amp", int'(bus.peak2_amp), m_e.p2);
                check("tof_err",   int'(bus.tof_err),   m_e.err);
                check("latency",   cyc,                 m_e.cyc);
                check("busy_at_strobe", int'(bus.busy), 0);
            end
        end
    end

    task automatic start_run(input case_t c);
        @(negedge clk);
        bus.blank_len     = CNT_W'(c.blank);
        bus.holdoff_len   = CNT_W'(c.hold);
        bus.gate_len      = CNT_W'(c.gate);
        bus.threshold     = (DATA_W-1)'(c.thr);
        bus.AD_data_valid = 1'b0;
        bus.burst_syn     = 1'b1;
        @(negedge clk);
        bus.burst_syn     = 1'b0;
    endtask

    task automatic drive_samples(input case_t c, input int first, input int last, input bit push);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            bus.AD_data_in    = DATA_W'(sample_at(i, c.e1, c.e2, c.spike));
            bus.AD_data_valid = 1'b1;
            if (push && i == c.close) begin
                e.tof = c.tof; e.p1 = c.p1; e.p2 = c.p2; e.err = c.err; e.cyc = cyc + 2;
                sb.push_back(e);
            end
            if (c.tog) begin
                // Full-scale garbage on invalid cycles must never be seen by the FSM.
                @(negedge clk);
                bus.AD_data_in    = DATA_W'(0);
                bus.AD_data_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.AD_data_in    = DATA_W'(512);
        bus.AD_data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic run_case(input case_t c);
        start_run(c);
        #1;
        check("busy_after_start", int'(bus.busy), 1);
        drive_samples(c, 0, c.close + 4, 1'b1);
        wait_drain();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tof_out"},   int'(bus.tof_out),   0);
        check({tag, "_peak1"},     int'(bus.peak1_amp), 0);
        check({tag, "_peak2"},     int'(bus.peak2_amp), 0);
        check({tag, "_tof_valid"}, int'(bus.tof_valid), 0);
        check({tag, "_tof_err"},   int'(bus.tof_err),   0);
        check({tag, "_busy"},      int'(bus.busy),      0);
    endtask

    initial begin
        //             blank hold gate  thr  e1   e2  spk tog close tof  p1  p2 err
        cases[0] = '{20, 10, 1000, 100, 50, 250, -1, 1'b0, 252, 200, 200, 168, 0};
        cases[1] = '{20, 10, 1000, 100, 50, 250, 10, 1'b0, 252, 200, 200, 168, 0};
        cases[2] = '{20, 10,  500, 100, -1,  -1, -1, 1'b0, 499,   0,   0,   0, 1};
        cases[3] = '{20, 10,  400, 100, 50,  -1, -1, 1'b0, 399,   0, 200,   0, 2};
        cases[4] = '{ 5,  3, 1000, 150, 30, 130, -1, 1'b0, 132, 100, 200, 168, 0};
        cases[5] = '{20, 10,  253, 100, 50, 250, -1, 1'b0, 252, 200, 200, 168, 0};
        cases[6] = '{20, 10,  252,  50, 50, 250, -1, 1'b0, 251, 200, 200, 168, 0};
        cases[7] = '{20, 10, 1000, 100, 50, 250, -1, 1'b1, 252, 200, 200, 168, 0};

        bus.burst_syn     = 1'b0;
        bus.AD_data_in    = DATA_W'(512);
        bus.AD_data_valid = 1'b0;
        bus.threshold     = '0;
        bus.blank_len     = '0;
        bus.holdoff_len   = '0;
        bus.gate_len      = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");

        for (int n = 0; n < 8; n++) run_case(cases[n]);

        // Restart while in HOLDOFF: the aborted run must never strobe.
        start_run(cases[0]);
        drive_samples(cases[0], 0, 58, 1'b0);
        #1;
        check("busy_before_abort", int'(bus.busy), 1);
        run_case(cases[4]);

        // Reset while inside echo 2 clears every output, including the held result.
        start_run(cases[0]);
        drive_samples(cases[0], 0, 251, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_peak2_reset");
        @(negedge clk);
        reset = 1'b0;
        // No start follows, so samples that would have closed echo 2 must be ignored.
        drive_samples(cases[0], 252, 260, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset_busy", int'(bus.busy), 0);
        run_case(cases[0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule
